// File: rtl/rr_arbiter_16_pkg.sv
// Shared constants and FSM encoding for the 16-way round-robin arbiter.
package rr_arbiter_16_pkg;

    localparam int ARB_N     = 16;
    localparam int ARB_IDX_W = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage : rr_arbiter_16_pkg

// File: rtl/rr_arbiter_16_dec.sv
// Enabled 4-to-16 one-hot decoder; all-zero output when disabled.
module one_hot_dec_4to16
    import rr_arbiter_16_pkg::*;
(
    input  logic [ARB_IDX_W-1:0] x,
    input  logic                 en,
    output logic [ARB_N-1:0]     y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[x] = 1'b1;
        end
    end

endmodule : one_hot_dec_4to16

// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter with hold-while-requested and optional
// pre-emption after MAX_HOLD cycles when other requesters are waiting.
//
// state     | meaning
// ARB_IDLE  | no grant active; search from r_last+1 each edge
// ARB_GRANT | r_idx holds the resource; r_hold counts consecutive cycles
module rr_arbiter_16
    import rr_arbiter_16_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [ARB_N-1:0]     req,
    output logic [ARB_N-1:0]     gnt,
    output logic [ARB_IDX_W-1:0] gnt_idx,
    output logic                 gnt_valid
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic [ARB_IDX_W-1:0] r_idx;
    logic [ARB_IDX_W-1:0] w_idx_nxt;
    logic [ARB_IDX_W-1:0] r_last;
    logic [ARB_IDX_W-1:0] w_last_nxt;
    logic [HOLD_W-1:0]    r_hold;
    logic [HOLD_W-1:0]    w_hold_nxt;
    logic [ARB_N-1:0]     w_gnt;
    logic                 w_valid;
    logic [ARB_IDX_W:0]   w_search_idle;
    logic [ARB_IDX_W:0]   w_search_oth;

    // Returns {found, index} of the first set bit strictly after base, wrapping
    // around; base itself is examined last. Descending loop lets the nearest win.
    function automatic logic [ARB_IDX_W:0] f_rr_search(
        input logic [ARB_N-1:0]     vec,
        input logic [ARB_IDX_W-1:0] base
    );
        logic [ARB_IDX_W:0]   res;
        logic [ARB_IDX_W-1:0] idx;
        res = '0;
        for (int i = ARB_N; i >= 1; i--) begin
            idx = base + i[ARB_IDX_W-1:0];
            if (vec[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_valid       = (r_state == ARB_GRANT);
    assign w_search_idle = f_rr_search(req, r_last);
    // Current holder masked out: serves both release handover and pre-emption.
    assign w_search_oth  = f_rr_search(req & ~w_gnt, r_idx);

    one_hot_dec_4to16 u_dec (
        .x  (r_idx),
        .en (w_valid),
        .y  (w_gnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        case (r_state)
            ARB_IDLE: begin
                if (en && w_search_idle[ARB_IDX_W]) begin
                    w_state_nxt = ARB_GRANT;
                    w_idx_nxt   = w_search_idle[ARB_IDX_W-1:0];
                    w_last_nxt  = w_search_idle[ARB_IDX_W-1:0];
                    w_hold_nxt  = '0;
                end
            end
            ARB_GRANT: begin
                if (!en) begin
                    w_state_nxt = ARB_IDLE;
                    w_idx_nxt   = '0;
                    w_hold_nxt  = '0;
                end else if (!req[r_idx]) begin
                    w_hold_nxt = '0;
                    if (w_search_oth[ARB_IDX_W]) begin
                        w_idx_nxt  = w_search_oth[ARB_IDX_W-1:0];
                        w_last_nxt = w_search_oth[ARB_IDX_W-1:0];
                    end else begin
                        w_state_nxt = ARB_IDLE;
                        w_idx_nxt   = '0;
                    end
                end else if (MAX_HOLD != 0 && r_hold == HOLD_LIM && w_search_oth[ARB_IDX_W]) begin
                    w_idx_nxt  = w_search_oth[ARB_IDX_W-1:0];
                    w_last_nxt = w_search_oth[ARB_IDX_W-1:0];
                    w_hold_nxt = '0;
                end else if (MAX_HOLD != 0 && r_hold != HOLD_LIM) begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_idx_nxt   = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_idx   <= '0;
            r_last  <= ARB_IDX_W'(ARB_N - 1);
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    assign gnt       = w_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = w_valid;

endmodule : rr_arbiter_16

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16: one instance without pre-emption and
// one with MAX_HOLD=8, driven by the same inputs.
module tb_rr_arbiter_16;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] req;
    logic [15:0] gnt0, gnt8;
    logic [3:0]  idx0, idx8;
    logic        vld0, vld8;

    int total;
    int bad;

    rr_arbiter_16 #(.MAX_HOLD(0), .HOLD_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(vld0)
    );

    rr_arbiter_16 #(.MAX_HOLD(8), .HOLD_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(vld8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({gnt0, idx0, vld0} !== 21'h0) begin
            bad++;
            $display("FAIL reset_dut0 got gnt=%h idx=%0d vld=%b want 0", gnt0, idx0, vld0);
        end
        total++;
        if ({gnt8, idx8, vld8} !== 21'h0) begin
            bad++;
            $display("FAIL reset_dut8 got gnt=%h idx=%0d vld=%b want 0", gnt8, idx8, vld8);
        end
        rst_n = 1'b1;
        en  = 1'b1;
        req = 16'h0001;
        tick();
        total++;
        if (gnt0 !== 16'h0001 || idx0 !== 4'd0 || vld0 !== 1'b1) begin
            bad++;
            $display("FAIL first_grant_dut0 got gnt=%h idx=%0d vld=%b want 0001/0/1", gnt0, idx0, vld0);
        end
        total++;
        if (gnt8 !== 16'h0001 || idx8 !== 4'd0 || vld8 !== 1'b1) begin
            bad++;
            $display("FAIL first_grant_dut8 got gnt=%h idx=%0d vld=%b want 0001/0/1", gnt8, idx8, vld8);
        end
    endtask

    task automatic test_handover_wrap();
        do_reset();
        en  = 1'b1;
        req = 16'h8001;
        tick();
        for (int k = 0; k < 12; k++) begin
            total++;
            if (gnt0 !== 16'h0001) begin
                bad++;
                $display("FAIL no_preempt_hold cyc=%0d got gnt=%h want 0001", k, gnt0);
            end
            tick();
        end
        req = 16'h8000;
        tick();
        total++;
        if (gnt0 !== 16'h8000 || idx0 !== 4'd15 || vld0 !== 1'b1) begin
            bad++;
            $display("FAIL handover_15 got gnt=%h idx=%0d vld=%b want 8000/15/1", gnt0, idx0, vld0);
        end
        req = 16'h0001;
        tick();
        total++;
        if (gnt0 !== 16'h0001 || idx0 !== 4'd0 || vld0 !== 1'b1) begin
            bad++;
            $display("FAIL wrap_15_to_0 got gnt=%h idx=%0d vld=%b want 0001/0/1", gnt0, idx0, vld0);
        end
        req = 16'h0000;
        tick();
        total++;
        if (gnt0 !== 16'h0000 || vld0 !== 1'b0 || idx0 !== 4'd0) begin
            bad++;
            $display("FAIL release_to_idle got gnt=%h idx=%0d vld=%b want 0000/0/0", gnt0, idx0, vld0);
        end
    endtask

    task automatic test_preempt();
        logic [3:0] exp_idx;
        do_reset();
        en  = 1'b1;
        req = 16'h0003;
        tick();
        for (int k = 0; k < 32; k++) begin
            exp_idx = ((k / 8) % 2 == 0) ? 4'd0 : 4'd1;
            total++;
            if (idx8 !== exp_idx || gnt8 !== (16'h0001 << exp_idx) || vld8 !== 1'b1) begin
                bad++;
                $display("FAIL preempt_alt cyc=%0d got idx=%0d gnt=%h want idx=%0d", k, idx8, gnt8, exp_idx);
            end
            // Non-granted requester toggling must not disturb the holder.
            req = (k == 3) ? 16'h0403 : 16'h0003;
            tick();
        end
    endtask

    task automatic test_sole_holder();
        do_reset();
        en  = 1'b1;
        req = 16'h0004;
        tick();
        for (int k = 0; k < 20; k++) begin
            total++;
            if (gnt8 !== 16'h0004 || idx8 !== 4'd2 || vld8 !== 1'b1) begin
                bad++;
                $display("FAIL sole_holder cyc=%0d got gnt=%h idx=%0d want 0004/2", k, gnt8, idx8);
            end
            tick();
        end
    endtask

    task automatic test_enable();
        do_reset();
        en  = 1'b0;
        req = 16'hFFFF;
        tick();
        total++;
        if (vld8 !== 1'b0 || gnt8 !== 16'h0000) begin
            bad++;
            $display("FAIL disabled_idle got gnt=%h vld=%b want 0000/0", gnt8, vld8);
        end
        en  = 1'b1;
        req = 16'h0020;
        tick();
        total++;
        if (idx8 !== 4'd5 || gnt8 !== 16'h0020) begin
            bad++;
            $display("FAIL grant_idx5 got idx=%0d gnt=%h want 5/0020", idx8, gnt8);
        end
        en = 1'b0;
        tick();
        total++;
        if (gnt8 !== 16'h0000 || vld8 !== 1'b0) begin
            bad++;
            $display("FAIL en_drop got gnt=%h vld=%b want 0000/0", gnt8, vld8);
        end
        en  = 1'b1;
        req = 16'hFFFF;
        tick();
        total++;
        if (idx8 !== 4'd6 || gnt8 !== 16'h0040 || vld8 !== 1'b1) begin
            bad++;
            $display("FAIL resume_idx6 got idx=%0d gnt=%h want 6/0040", idx8, gnt8);
        end
    endtask

    task automatic test_async_reset();
        req = 16'h0200;
        tick();
        total++;
        if (idx8 !== 4'd9 || gnt8 !== 16'h0200) begin
            bad++;
            $display("FAIL grant_idx9 got idx=%0d gnt=%h want 9/0200", idx8, gnt8);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (gnt8 !== 16'h0000 || vld8 !== 1'b0 || idx8 !== 4'd0) begin
            bad++;
            $display("FAIL async_reset got gnt=%h idx=%0d vld=%b want 0000/0/0", gnt8, idx8, vld8);
        end
        req = 16'hFFFF;
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (idx8 !== 4'd0 || gnt8 !== 16'h0001 || vld8 !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_idx0 got idx=%0d gnt=%h want 0/0001", idx8, gnt8);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        test_reset();
        test_handover_wrap();
        test_preempt();
        test_sole_holder();
        test_enable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rr_arbiter_16
